// File: rtl/regs_bus_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the register-file decoder bus.
// The arbiter connects through the slave modport; requesters and register file use master.
interface regs_bus_arbiter_if;
    logic       req0, req1;
    logic       we0, we1;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       lock0, lock1;
    logic       busy0, busy1;
    logic       rej0, rej1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       read, write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        output busy0, busy1, rej0, rej1, ack0, ack1, rdata0, rdata1,
        output read, write, addr, data_write,
        input  data_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        input  busy0, busy1, rej0, rej1, ack0, ack1, rdata0, rdata1,
        input  read, write, addr, data_write,
        output data_read
    );
endinterface

// File: rtl/regs_bus_arbiter.sv
// Round-robin arbiter sharing the register-file access bus between two buffered ports,
// with an optional bus lock that is released by the owner or by an idle timeout.
//   state    | meaning
//   S_IDLE   | pick an eligible pending slot, count idle-owner cycles while locked
//   S_ACCESS | drive one read/write cycle for slot[gnt]
//   S_ACK    | pulse ack[gnt], free slot[gnt], update lock
module regs_bus_arbiter #(
    parameter int LOCK_TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    regs_bus_arbiter_if.slave bus
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;

    state_t          state_q, state_d;
    logic            gnt_q, gnt_d;
    logic            last_grant_q;
    logic [1:0]      slot_vld_q, slot_we_q, slot_lock_q;
    logic [5:0]      slot_addr_q  [2];
    logic [7:0]      slot_wdata_q [2];
    logic            lock_act_q, lock_owner_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [1:0]      rej_q;
    logic [7:0]      rdata_q [2];

    logic [1:0]      req_w, we_w, lock_w;
    logic [5:0]      addr_in_w  [2];
    logic [7:0]      wdata_in_w [2];
    logic            idle_owner_w, expire_w, lock_eff_w;
    logic [1:0]      elig_w;
    logic            read_w, write_w;
    logic [5:0]      addr_w;
    logic [7:0]      dwr_w;
    logic [1:0]      ack_w;

    assign req_w         = {bus.req1, bus.req0};
    assign we_w          = {bus.we1, bus.we0};
    assign lock_w        = {bus.lock1, bus.lock0};
    assign addr_in_w[0]  = bus.addr0;
    assign addr_in_w[1]  = bus.addr1;
    assign wdata_in_w[0] = bus.wdata0;
    assign wdata_in_w[1] = bus.wdata1;

    // The expiring cycle already counts as unlocked so the waiting port is granted at once.
    assign idle_owner_w = (state_q == S_IDLE) && lock_act_q && !slot_vld_q[lock_owner_q];
    assign expire_w     = idle_owner_w && (tmo_cnt_q == '0);
    assign lock_eff_w   = lock_act_q && !expire_w;
    assign elig_w       = lock_eff_w ? (slot_vld_q & (lock_owner_q ? 2'b10 : 2'b01)) : slot_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (|elig_w) begin
                    state_d = S_ACCESS;
                    gnt_d   = (&elig_w) ? !last_grant_q : elig_w[1];
                end
            end
            S_ACCESS: state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        read_w  = 1'b0;
        write_w = 1'b0;
        addr_w  = '0;
        dwr_w   = '0;
        ack_w   = '0;
        case (state_q)
            S_ACCESS: begin
                read_w  = !slot_we_q[gnt_q];
                write_w = slot_we_q[gnt_q];
                addr_w  = slot_addr_q[gnt_q];
                dwr_w   = slot_wdata_q[gnt_q];
            end
            S_ACK:   ack_w[gnt_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q   <= '0;
            slot_we_q    <= '0;
            slot_lock_q  <= '0;
            last_grant_q <= 1'b1;
            lock_act_q   <= 1'b0;
            lock_owner_q <= 1'b0;
            tmo_cnt_q    <= '0;
            rej_q        <= '0;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
                rdata_q[i]      <= '0;
            end
        end else begin
            rej_q <= req_w & slot_vld_q;
            for (int i = 0; i < 2; i++) begin
                if (req_w[i] && !slot_vld_q[i]) begin
                    slot_vld_q[i]   <= 1'b1;
                    slot_we_q[i]    <= we_w[i];
                    slot_lock_q[i]  <= lock_w[i];
                    slot_addr_q[i]  <= addr_in_w[i];
                    slot_wdata_q[i] <= wdata_in_w[i];
                end else if (state_q == S_ACK && gnt_q == 1'(i)) begin
                    slot_vld_q[i] <= 1'b0;
                end
            end

            if (state_q == S_IDLE && state_d == S_ACCESS) begin
                last_grant_q <= gnt_d;
                tmo_cnt_q    <= TW'(LOCK_TIMEOUT - 1);
            end else if (idle_owner_w && tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - 1'b1;
            end

            if (expire_w)
                lock_act_q <= 1'b0;

            if (state_q == S_ACCESS && !slot_we_q[gnt_q])
                rdata_q[gnt_q] <= bus.data_read;

            if (state_q == S_ACK) begin
                if (slot_lock_q[gnt_q]) begin
                    lock_act_q   <= 1'b1;
                    lock_owner_q <= gnt_q;
                end else if (lock_act_q && lock_owner_q == gnt_q) begin
                    lock_act_q <= 1'b0;
                end
            end
        end
    end

    assign bus.busy0      = slot_vld_q[0];
    assign bus.busy1      = slot_vld_q[1];
    assign bus.rej0       = rej_q[0];
    assign bus.rej1       = rej_q[1];
    assign bus.ack0       = ack_w[0];
    assign bus.ack1       = ack_w[1];
    assign bus.rdata0     = rdata_q[0];
    assign bus.rdata1     = rdata_q[1];
    assign bus.read       = read_w;
    assign bus.write      = write_w;
    assign bus.addr       = addr_w;
    assign bus.data_write = dwr_w;
endmodule

// File: tb/tb_regs_bus_arbiter.sv
// Scoreboard bench for regs_bus_arbiter: expected bus accesses are queued with the stimulus
// and matched against accesses observed on the register-file side.
module tb_regs_bus_arbiter;
    localparam int LT = 16;

    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [7:0] data;
        int         cyc;
    } acc_t;

    logic clk, rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ack0_cnt = 0;
    int   ack1_cnt = 0;
    acc_t exp_q[$];
    acc_t obs_q[$];
    logic [7:0] mem [64];

    regs_bus_arbiter_if bus();

    regs_bus_arbiter #(.LOCK_TIMEOUT(LT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register-file model
    initial for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    always @(posedge clk) if (bus.write) mem[bus.addr] <= bus.data_write;
    assign bus.data_read = bus.read ? mem[bus.addr] : 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.read || bus.write)
                obs_q.push_back('{bus.write, bus.addr, bus.data_write, cyc});
            if (bus.ack0) ack0_cnt++;
            if (bus.ack1) ack1_cnt++;
        end
    end

    task automatic post(input bit p, input bit we, input logic [5:0] a, input logic [7:0] d, input bit lk);
        if (!p) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = lk;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = lk;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic to_cycle(input int n);
        for (int k = 0; k < 1000 && cyc < n; k++) step();
    endtask

    task automatic wait_obs(input int budget, output acc_t o, output bit ok);
        ok = 1'b0;
        o  = '{1'b0, 6'h0, 8'h0, -1};
        for (int i = 0; i < budget && !ok; i++) begin
            if (obs_q.size() > 0) begin
                o  = obs_q.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.busy0, bus.busy1, bus.rej0, bus.rej1, bus.ack0, bus.ack1, bus.read, bus.write} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, want 00000000",
                     {bus.busy0, bus.busy1, bus.rej0, bus.rej1, bus.ack0, bus.ack1, bus.read, bus.write});
        end
        n_cmp++;
        if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_rdata: got %h %h, want 00 00", bus.rdata0, bus.rdata1);
        end
        n_cmp++;
        if ({bus.addr, bus.data_write} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_bus: got addr=%h data_write=%h, want 00 00", bus.addr, bus.data_write);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_contention();
        acc_t o, e;
        bit   ok;
        int   t;
        t = cyc;
        post(0, 1, 6'h02, 8'h11, 0);
        post(1, 1, 6'h03, 8'h22, 0);
        exp_q.push_back('{1'b1, 6'h02, 8'h11, t + 2});
        exp_q.push_back('{1'b1, 6'h03, 8'h22, t + 5});
        step();
        to_cycle(t + 7);
        t = cyc;
        post(0, 1, 6'h04, 8'h33, 0);
        exp_q.push_back('{1'b1, 6'h04, 8'h33, t + 2});
        step();
        to_cycle(t + 4);
        t = cyc;
        post(0, 1, 6'h05, 8'h44, 0);
        post(1, 1, 6'h06, 8'h55, 0);
        exp_q.push_back('{1'b1, 6'h06, 8'h55, t + 2});
        exp_q.push_back('{1'b1, 6'h05, 8'h44, t + 5});
        step();
        to_cycle(t + 8);
        for (int k = 0; k < 5; k++) begin
            wait_obs(10, o, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || o.we !== e.we || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
                n_err++;
                $display("FAIL contention_access%0d: got ok=%0b we=%0b addr=%h data=%h cyc=%0d, want we=%0b addr=%h data=%h cyc=%0d",
                         k, ok, o.we, o.addr, o.data, o.cyc, e.we, e.addr, e.data, e.cyc);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL contention_extra: got %0d extra accesses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_write_read();
        acc_t o, e;
        bit   ok;
        int   t;
        t = cyc;
        post(0, 1, 6'h00, 8'hA5, 0);
        exp_q.push_back('{1'b1, 6'h00, 8'hA5, t + 2});
        step();
        wait_obs(10, o, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || o.we !== e.we || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
            n_err++;
            $display("FAIL write_access: got ok=%0b we=%0b addr=%h data=%h cyc=%0d, want 1 00 a5 cyc=%0d",
                     ok, o.we, o.addr, o.data, o.cyc, e.cyc);
        end
        to_cycle(t + 3);
        n_cmp++;
        if (bus.ack0 !== 1'b1 || bus.busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL write_ack: got ack0=%b busy0=%b, want 1 1", bus.ack0, bus.busy0);
        end
        to_cycle(t + 4);
        n_cmp++;
        if (bus.busy0 !== 1'b0 || bus.ack0 !== 1'b0) begin
            n_err++;
            $display("FAIL write_free: got busy0=%b ack0=%b, want 0 0", bus.busy0, bus.ack0);
        end
        t = cyc;
        post(0, 0, 6'h00, 8'h00, 0);
        exp_q.push_back('{1'b0, 6'h00, 8'h00, t + 2});
        step();
        wait_obs(10, o, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || o.we !== e.we || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
            n_err++;
            $display("FAIL read_access: got ok=%0b we=%0b addr=%h cyc=%0d, want 0 00 cyc=%0d",
                     ok, o.we, o.addr, o.cyc, e.cyc);
        end
        to_cycle(t + 3);
        n_cmp++;
        if (bus.ack0 !== 1'b1 || bus.rdata0 !== 8'hA5) begin
            n_err++;
            $display("FAIL read_ack: got ack0=%b rdata0=%h, want 1 a5", bus.ack0, bus.rdata0);
        end
        to_cycle(t + 5);
    endtask

    task automatic test_lock();
        acc_t o, e;
        bit   ok;
        int   t;
        t = cyc;
        post(1, 1, 6'h00, 8'h5A, 1);
        exp_q.push_back('{1'b1, 6'h00, 8'h5A, t + 2});
        exp_q.push_back('{1'b1, 6'h01, 8'h6B, t + 6});
        exp_q.push_back('{1'b1, 6'h05, 8'h33, t + 9});
        step();
        post(0, 1, 6'h05, 8'h33, 0);
        step();
        to_cycle(t + 4);
        post(1, 1, 6'h01, 8'h6B, 0);
        step();
        n_cmp++;
        if (bus.busy0 !== 1'b1 || bus.rej0 !== 1'b0) begin
            n_err++;
            $display("FAIL lock_wait: got busy0=%b rej0=%b, want 1 0", bus.busy0, bus.rej0);
        end
        to_cycle(t + 12);
        for (int k = 0; k < 3; k++) begin
            wait_obs(10, o, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || o.we !== e.we || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
                n_err++;
                $display("FAIL lock_access%0d: got ok=%0b we=%0b addr=%h data=%h cyc=%0d, want we=%0b addr=%h data=%h cyc=%0d",
                         k, ok, o.we, o.addr, o.data, o.cyc, e.we, e.addr, e.data, e.cyc);
            end
        end
        n_cmp++;
        if (bus.rdata0 !== 8'hA5) begin
            n_err++;
            $display("FAIL rdata_hold: got rdata0=%h, want a5", bus.rdata0);
        end
    endtask

    task automatic test_lock_timeout();
        acc_t o, e;
        bit   ok;
        int   t;
        t = cyc;
        post(0, 1, 6'h0C, 8'h66, 1);
        exp_q.push_back('{1'b1, 6'h0C, 8'h66, t + 2});
        step();
        post(1, 1, 6'h0D, 8'h77, 0);
        step();
        wait_obs(10, o, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || o.we !== e.we || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
            n_err++;
            $display("FAIL tmo_owner: got ok=%0b addr=%h data=%h cyc=%0d, want 0c 66 cyc=%0d",
                     ok, o.addr, o.data, o.cyc, e.cyc);
        end
        to_cycle(t + 10);
        n_cmp++;
        if (bus.busy1 !== 1'b1 || bus.rej1 !== 1'b0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL tmo_held: got busy1=%b rej1=%b accesses=%0d, want 1 0 0",
                     bus.busy1, bus.rej1, obs_q.size());
        end
        wait_obs(3 * LT, o, ok);
        n_cmp++;
        if (!ok || o.addr !== 6'h0D || o.data !== 8'h77 || o.cyc < t + 3 + LT || o.cyc > t + 5 + LT) begin
            n_err++;
            $display("FAIL tmo_release: got ok=%0b addr=%h data=%h cyc=%0d, want 0d 77 cyc in %0d..%0d",
                     ok, o.addr, o.data, o.cyc, t + 3 + LT, t + 5 + LT);
        end
        to_cycle(cyc + 6);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL tmo_extra: got %0d extra accesses, want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reject();
        acc_t o;
        bit   ok;
        int   t, a0;
        a0 = ack0_cnt;
        t = cyc;
        post(0, 1, 6'h07, 8'h77, 0);
        step();
        post(0, 1, 6'h08, 8'h88, 0);
        step();
        n_cmp++;
        if (bus.rej0 !== 1'b1) begin
            n_err++;
            $display("FAIL rej_busy: got rej0=%b, want 1", bus.rej0);
        end
        step();
        n_cmp++;
        if (bus.ack0 !== 1'b1 || bus.rej0 !== 1'b0) begin
            n_err++;
            $display("FAIL rej_ackcycle: got ack0=%b rej0=%b, want 1 0", bus.ack0, bus.rej0);
        end
        post(0, 1, 6'h09, 8'h99, 0);
        step();
        n_cmp++;
        if (bus.rej0 !== 1'b1 || bus.busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL rej_in_ack: got rej0=%b busy0=%b, want 1 0", bus.rej0, bus.busy0);
        end
        to_cycle(t + 10);
        wait_obs(2, o, ok);
        n_cmp++;
        if (!ok || o.addr !== 6'h07 || o.data !== 8'h77 || o.cyc != t + 2 || obs_q.size() != 0 || ack0_cnt != a0 + 1) begin
            n_err++;
            $display("FAIL rej_bus: got ok=%0b addr=%h data=%h cyc=%0d extra=%0d acks=%0d, want 07 77 cyc=%0d extra=0 acks=1",
                     ok, o.addr, o.data, o.cyc, obs_q.size(), ack0_cnt - a0, t + 2);
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        acc_t o, e;
        bit   ok;
        int   t, a0;
        t = cyc;
        post(0, 1, 6'h0A, 8'hAA, 0);
        step();
        step();
        n_cmp++;
        if (bus.write !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: got write=%b, want 1", bus.write);
        end
        a0 = ack0_cnt;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy0, bus.busy1, bus.rej0, bus.rej1, bus.ack0, bus.ack1, bus.read, bus.write} !== 8'h00 ||
            bus.addr !== 6'h00 || bus.data_write !== 8'h00) begin
            n_err++;
            $display("FAIL rstmid_outputs: got ctrl=%b addr=%h data_write=%h, want 0 00 00",
                     {bus.busy0, bus.busy1, bus.rej0, bus.rej1, bus.ack0, bus.ack1, bus.read, bus.write},
                     bus.addr, bus.data_write);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        to_cycle(cyc + 4);
        n_cmp++;
        if (ack0_cnt != a0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_abort: got acks=%0d accesses=%0d, want 0 0", ack0_cnt - a0, obs_q.size());
            obs_q.delete();
        end
        t = cyc;
        post(0, 1, 6'h10, 8'hC0, 0);
        post(1, 1, 6'h11, 8'hC1, 0);
        exp_q.push_back('{1'b1, 6'h10, 8'hC0, t + 2});
        exp_q.push_back('{1'b1, 6'h11, 8'hC1, t + 5});
        step();
        to_cycle(t + 8);
        for (int k = 0; k < 2; k++) begin
            wait_obs(10, o, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || o.addr !== e.addr || o.data !== e.data || o.cyc != e.cyc) begin
                n_err++;
                $display("FAIL rstmid_tie%0d: got ok=%0b addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                         k, ok, o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
            end
        end
    endtask

    initial begin
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.lock0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.lock1 = 0;
        rst = 1'b1;
        test_reset();
        test_contention();
        test_write_read();
        test_lock();
        test_lock_timeout();
        test_reject();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
